// File: rtl/instr_sequencer.sv
// Instruction program buffer with a replay sequencer: words are loaded while idle, then
// issued one at a time through the datapath and display handshakes.
module instr_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [17:0]                push_word,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       exec_ready,
  input  logic                       exec_done,
  input  logic                       lcd_ready,
  output logic [17:0]                instr_out,
  output logic                       exec_valid,
  output logic                       lcd_update,
  output logic [$clog2(DEPTH)-1:0]   pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_EXEC,
    WAIT_LCD,
    NEXT
  } state_t;

  state_t       state;
  logic [17:0]  buffer [DEPTH];
  logic [AW-1:0] pc_inc;
  logic         last;
  logic         write_en;

  assign busy  = (state != IDLE);
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  assign pc_inc = pc + 1'b1;
  assign last   = (({1'b0, pc} + 1'b1) == count);

  // Only accepted pushes write; a push against a full buffer leaves the last entry intact.
  assign write_en = reset && (state == IDLE) && push && !clear && !full;

  // NOTE: the buffer has no reset; its contents are only ever read below count, which does reset.
  always_ff @(posedge clock) begin
    if (write_en) begin
      buffer[count[AW-1:0]] <= push_word;
    end
  end

  // NOTE: all state and outputs are updated with non-blocking assignments so every read
  // in this block sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      pc         <= '0;
      exec_valid <= 1'b0;
      lcd_update <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      instr_out  <= '0;
    end else begin
      lcd_update <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        exec_valid <= 1'b0;
        pc         <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (clear) begin
              count    <= '0;
              overflow <= 1'b0;
            end else if (push) begin
              if (!full) count <= count + 1'b1;
              else       overflow <= 1'b1;
            end
            // A start alongside clear would replay a buffer that is being emptied, so it is dropped.
            if (start && !abort && !clear && !empty) begin
              pc         <= '0;
              state      <= ISSUE;
              exec_valid <= 1'b1;
              instr_out  <= buffer[{AW{1'b0}}];
            end
          end
          ISSUE: begin
            if (exec_ready) begin
              state      <= WAIT_EXEC;
              exec_valid <= 1'b0;
            end
          end
          WAIT_EXEC: begin
            if (exec_done) state <= WAIT_LCD;
          end
          WAIT_LCD: begin
            if (lcd_ready) begin
              lcd_update <= 1'b1;
              state      <= NEXT;
            end
          end
          NEXT: begin
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
              pc    <= '0;
            end else begin
              pc         <= pc_inc;
              state      <= ISSUE;
              exec_valid <= 1'b1;
              instr_out  <= buffer[pc_inc];
            end
          end
          default: begin
            state      <= IDLE;
            exec_valid <= 1'b0;
            pc         <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table for loading/overflow plus
// hand-written sequences for replay, backpressure, abort and mid-replay reset.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        push;
  logic [17:0] push_word;
  logic        clear;
  logic        start;
  logic        abort;
  logic        exec_ready;
  logic        exec_done;
  logic        lcd_ready;
  logic [17:0] instr_out;
  logic        exec_valid;
  logic        lcd_update;
  logic [2:0]  pc;
  logic [3:0]  count;
  logic        busy;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  instr_sequencer #(.DEPTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_word  (push_word),
    .clear      (clear),
    .start      (start),
    .abort      (abort),
    .exec_ready (exec_ready),
    .exec_done  (exec_done),
    .lcd_ready  (lcd_ready),
    .instr_out  (instr_out),
    .exec_valid (exec_valid),
    .lcd_update (lcd_update),
    .pc         (pc),
    .count      (count),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        push;
    logic [17:0] word;
    logic        clear;
    logic        start;
    logic [3:0]  exp_count;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_overflow;
    logic        exp_busy;
  } vec_t;

  logic [17:0] words [8];
  vec_t        vecs  [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start a replay of n entries with all handshakes high; done is due exactly 4*n edges later.
  task automatic replay_check(input int n);
    int cyc;
    int issued;
    int lcd_n;
    start = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 0;
    issued = 0;
    lcd_n  = 0;
    while (!done && cyc < 64) begin
      if (exec_valid) begin
        if (issued < n) check($sformatf("issue_%0d", issued), 32'(instr_out), 32'(words[issued]));
        issued++;
      end
      if (lcd_update) lcd_n++;
      tick();
      cyc++;
    end
    check("done_cycle", cyc, 4 * n);
    check("issue_count", issued, n);
    check("lcd_pulses", lcd_n, n);
    check("pc_after_done", 32'(pc), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    words[0] = 18'h00005; words[1] = 18'h08801; words[2] = 18'h10C02; words[3] = 18'h18003;
    words[4] = 18'h20004; words[5] = 18'h28005; words[6] = 18'h30006; words[7] = 18'h38007;

    //            push word       clr start cnt   full empty ovf busy
    vecs[0]  = '{1'b0, 18'h0,     1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, words[0],  1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, words[1],  1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, words[2],  1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, words[3],  1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, words[4],  1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, words[5],  1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, words[6],  1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, words[7],  1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 18'h3FFFF, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 18'h3FFFE, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b0; push = 1'b0; push_word = '0; clear = 1'b0; start = 1'b0; abort = 1'b0;
    exec_ready = 1'b1; exec_done = 1'b1; lcd_ready = 1'b1;
    tick();
    tick();

    check("rst_instr_out", 32'(instr_out), 32'd0);
    check("rst_exec_valid", 32'(exec_valid), 32'd0);
    check("rst_lcd_update", 32'(lcd_update), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;

    // Load to overflow, starting with a start against an empty buffer.
    for (int i = 0; i < 11; i++) begin
      push = vecs[i].push; push_word = vecs[i].word; clear = vecs[i].clear; start = vecs[i].start;
      tick();
      push = 1'b0; clear = 1'b0; start = 1'b0;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_overflow));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end

    // Full replay shows entry 7 survived the rejected pushes.
    replay_check(8);

    // Clear wins over a simultaneous push.
    clear = 1'b1; push = 1'b1; push_word = 18'h12345;
    tick();
    clear = 1'b0; push = 1'b0;
    check("clear_count", 32'(count), 32'd0);
    check("clear_empty", 32'(empty), 32'd1);
    check("clear_full", 32'(full), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);

    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_word = words[i];
      tick();
    end
    push = 1'b0;
    check("load3_count", 32'(count), 32'd3);
    replay_check(3);

    // Backpressure on the datapath handshake.
    exec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), 32'(exec_valid), 32'd1);
      check($sformatf("bp_word_%0d", i), 32'(instr_out), 32'(words[0]));
      tick();
    end
    clear = 1'b1; push = 1'b1; push_word = 18'h2AAAA;
    tick();
    clear = 1'b0; push = 1'b0;
    check("busy_clear_ignored", 32'(count), 32'd3);
    check("busy_push_no_ovf", 32'(overflow), 32'd0);
    check("bp_still_valid", 32'(exec_valid), 32'd1);

    exec_ready = 1'b1; exec_done = 1'b0;
    tick();
    check("wait_exec_valid", 32'(exec_valid), 32'd0);
    tick();
    check("wait_exec_busy", 32'(busy), 32'd1);
    check("wait_exec_no_lcd", 32'(lcd_update), 32'd0);

    // Display backpressure.
    lcd_ready = 1'b0; exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lcd_held_%0d", i), 32'(lcd_update), 32'd0);
      tick();
    end
    lcd_ready = 1'b1;
    tick();
    check("lcd_pulse", 32'(lcd_update), 32'd1);
    tick();
    check("issue1_valid", 32'(exec_valid), 32'd1);
    check("issue1_word", 32'(instr_out), 32'(words[1]));
    check("issue1_pc", 32'(pc), 32'd1);
    check("lcd_pulse_ends", 32'(lcd_update), 32'd0);

    // Abort while entry 1 waits for writeback.
    tick();
    check("entry1_wait_exec", 32'(exec_valid), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_valid", 32'(exec_valid), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_count", 32'(count), 32'd3);
    tick();
    check("abort_no_done_late", 32'(done), 32'd0);

    exec_done = 1'b1; exec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_valid", 32'(exec_valid), 32'd1);
    check("restart_word", 32'(instr_out), 32'(words[0]));
    check("restart_pc", 32'(pc), 32'd0);

    // Start and abort together: abort wins, both mid-replay and from idle.
    start = 1'b1; abort = 1'b1;
    tick();
    check("start_abort_busy_run", 32'(busy), 32'd0);
    check("start_abort_valid", 32'(exec_valid), 32'd0);
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy_idle", 32'(busy), 32'd0);
    exec_ready = 1'b1;

    // Reset while entry 1 is requesting a display refresh.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre_rst_lcd", 32'(lcd_update), 32'd1);
    check("pre_rst_pc", 32'(pc), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_valid", 32'(exec_valid), 32'd0);
    check("mid_rst_lcd", 32'(lcd_update), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_instr", 32'(instr_out), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: program-buffer entries (power of two).
REQ-002 SHALL have port clock, input, 1: rising-edge clock.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port push, input, 1: one-cycle pulse; append push_word to the program buffer.
REQ-005 SHALL have port push_word, input, 18: instruction word, same encoding as front-panel switches (opcode [17:15], dest [14:11]).
REQ-006 SHALL have port clear, input, 1: pulse; empty the program buffer.
REQ-007 SHALL have port start, input, 1: pulse; begin replay from entry 0.
REQ-008 SHALL have port abort, input, 1: pulse; stop replay.
REQ-009 SHALL have port exec_ready, input, 1: datapath accepts the issued instruction.
REQ-010 SHALL have port exec_done, input, 1: datapath writeback complete, one-cycle pulse.
REQ-011 SHALL have port lcd_ready, input, 1: display idle.
REQ-012 SHALL have port instr_out, output, 18: word currently issued.
REQ-013 SHALL have port exec_valid, output, 1: instr_out valid for the datapath.
REQ-014 SHALL have port lcd_update, output, 1: one-cycle display refresh request.
REQ-015 SHALL have port pc, output, log2(DEPTH): index of the current entry.
REQ-016 SHALL have port count, output, log2(DEPTH)+1: number of stored entries.
REQ-017 SHALL have ports busy, full, empty, overflow, done, output, 1 each: status flags.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_EXEC, WAIT_LCD, NEXT.
REQ-019 SHALL, in IDLE, write push_word to entry count and increment count on push when count<DEPTH.
REQ-020 SHALL, on push with count==DEPTH, not write, hold count, and set sticky overflow.
REQ-021 SHALL ignore push and clear outside IDLE; overflow is not set by these ignored pushes.
REQ-022 SHALL, on clear in IDLE, set count=0 and overflow=0; clear takes priority over a simultaneous push.
REQ-023 SHALL, on start in IDLE with count!=0, set pc=0 and enter ISSUE next cycle; start with count==0 is ignored.
REQ-024 SHALL, in ISSUE, drive exec_valid=1 and instr_out=buffer[pc], holding both stable until exec_ready; on exec_ready go to WAIT_EXEC.
REQ-025 SHALL, in WAIT_EXEC, hold exec_valid=0 and go to WAIT_LCD on exec_done; an exec_done outside WAIT_EXEC is ignored.
REQ-026 SHALL, in WAIT_LCD, when lcd_ready=1, assert lcd_update for exactly one cycle and go to NEXT.
REQ-027 SHALL, in NEXT, go to IDLE with a one-cycle done pulse when pc==count-1; otherwise increment pc and go to ISSUE.
REQ-028 SHALL, on abort in any non-IDLE state, enter IDLE next cycle with exec_valid=0, lcd_update=0, pc=0, no done pulse; buffer contents are kept.
REQ-029 SHALL give abort priority over start when both occur in the same cycle.
REQ-030 SHALL drive busy=1 in every state except IDLE, full=(count==DEPTH), and empty=(count==0).
REQ-031 SHALL achieve minimum per-instruction latency with exec_ready, exec_done, and lcd_ready all high: 4 cycles (ISSUE, WAIT_EXEC, WAIT_LCD, NEXT).

Reset
REQ-032 SHALL, while reset=0 at a clock edge, set state=IDLE, count=0, pc=0, exec_valid=0, lcd_update=0, overflow=0, done=0, and instr_out=0.
REQ-033 SHALL, on reset mid-replay, drop exec_valid and lcd_update on the same edge; buffer contents need not be cleared.

Verification
REQ-034 Load then replay: push 3 words (e.g. 18'h00005, 18'h08801, 18'h10C02), start, all handshakes high -> three exec_valid issues in order, 3 lcd_update pulses, done at cycle 12, pc back to 0.
REQ-035 Overflow: push 9 words with DEPTH=8 -> count=8, full=1, overflow=1, entry 7 unchanged; clear -> count=0, empty=1, overflow=0.
REQ-036 Backpressure: exec_ready low for 5 cycles in ISSUE -> instr_out and exec_valid stable for all 5 cycles; lcd_ready low -> no lcd_update until it rises.
REQ-037 Abort mid-run: abort in WAIT_EXEC of entry 1 -> IDLE next cycle, no done, count unchanged; a later start replays from entry 0.
REQ-038 Corner cases: start with count=0 -> busy stays 0; start+abort in the same cycle -> IDLE; push during replay -> count unchanged; reset=0 mid-replay -> all outputs at their reset values on the next edge.
